// File: rtl/inmod_cnt_bank.sv
// Per-input-module fill-level counters for the shared line buffer; INMOD_CNT_ERR_EN enables sticky underflow flags.
// Latency: writes/consumes visible on cnt_bus one cycle later. Backpressure: in_ready drops at full or outside RUN.
module inmod_cnt_bank #(
  parameter int MODI = 6,
  parameter int ADDW = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frm_start,
  input  logic                 frm_end,
  input  logic [MODI-1:0]      in_valid,
  output logic [MODI-1:0]      in_ready,
  input  logic                 rd_en,
  input  logic [ADDW-1:0]      rd_num,
  output logic [MODI*ADDW-1:0] cnt_bus,
  output logic [MODI-1:0]      full,
  output logic                 busy,
  output logic                 frm_done,
  output logic [MODI-1:0]      err
);

  localparam logic [ADDW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [MODI-1:0][ADDW-1:0]  level, level_nxt;
  logic [MODI-1:0][ADDW:0]    diff;
  logic [MODI-1:0]            uflow;
  logic [ADDW-1:0]            dec;
  logic                       all_zero;

  assign cnt_bus  = level;
  assign busy     = (state != IDLE);
  assign frm_done = (state == DONE);
  assign all_zero = (level == '0);
  assign dec      = (rd_en && (state == RUN || state == DRAIN)) ? rd_num : '0;

  always_comb begin
    in_ready  = '0;
    full      = '0;
    diff      = '0;
    uflow     = '0;
    level_nxt = level;
    for (int i = 0; i < MODI; i++) begin
      full[i]     = (level[i] == CNT_MAX);
      in_ready[i] = (state == RUN) && !full[i] && !frm_start;
      // ADDW+1-bit signed: level+inc never exceeds CNT_MAX, so the sign bit flags underflow
      diff[i]     = {1'b0, level[i]} + {{ADDW{1'b0}}, (in_valid[i] & in_ready[i])}
                  - {1'b0, dec};
      uflow[i]    = diff[i][ADDW] && !frm_start;
      level_nxt[i] = diff[i][ADDW] ? '0 : diff[i][ADDW-1:0];
    end
    if (frm_start) begin
      level_nxt = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    if (frm_start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (frm_end) state_nxt = DRAIN;
        DRAIN:   if (all_zero) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      level <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

`ifdef INMOD_CNT_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= '0;
    end else if (frm_start) begin
      err <= '0;
    end else begin
      err <= err | uflow;
    end
  end
`else
  assign err = '0;
`endif

endmodule
